bench_vec_sequencer: RTL and testbench
======================================

# bench_vec_sequencer

Sequencer and arbiter that shares one combinational power-benchmark netlist (85 primary inputs, 66 primary outputs) between two stimulus requesters. It grants one requester at a time, drives its vector onto the netlist inputs, and waits a fixed settle interval. It then captures the netlist outputs and returns them with a per-vector output-toggle count, which feeds switching-activity estimation in the power-aware synthesis flow. It sits between the stimulus sources and the benchmark netlist instance.

## Interface
- IN_W, 85, netlist primary-input width
- OUT_W, 66, netlist primary-output width
- SETTLE_CYC, 2, cycles between driving `dut_in` and capturing `dut_out`; legal 1..16
- CNT_W, 32, width of the accumulated toggle counter
- TW, $clog2(OUT_W+1), derived width of the per-vector toggle count (7 at default)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a vector
- req0_vec / req1_vec  in  IN_W  stimulus vector
- req0_ready / req1_ready  out  1  vector accepted this cycle
- dut_in  out  IN_W  registered drive to the netlist inputs
- dut_out  in  OUT_W  netlist outputs (combinational from `dut_in`)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_vec  out  OUT_W  captured `dut_out`
- rsp_toggles  out  TW  popcount(capture XOR previous capture)
- total_toggles  out  CNT_W  saturating sum of `rsp_toggles`
- stat_clr  in  1  clears `total_toggles` and the previous-capture register
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE transitions to SETTLE on a request handshake. The accepted vector loads into `dut_in`, the settle counter loads SETTLE_CYC-1, and `rsp_id` latches the grant.
- SETTLE: the counter decrements each cycle. When the counter is 0 at an edge, `rsp_vec` captures `dut_out`, toggles are computed, and the FSM moves to RESP.
- RESP: `rsp_valid` = 1; `rsp_vec`, `rsp_id` and `rsp_toggles` stay stable until `rsp_ready`. On that handshake the FSM returns to IDLE.
- Arbitration is round-robin:
  - `reqN_ready` = IDLE & `reqN_valid` & (!`reqOther_valid` | `prio` == N).
  - `prio` flips to the non-served requester on each accept.
  - `prio` resets to 0.
  - At most one ready is high per cycle.
- Requesters must not make valid depend on ready. Once valid is raised, valid and vec are held until accepted.
- `dut_in` holds the last accepted vector after the transaction; it is never re-zeroed between vectors, to avoid injecting spurious switching.
- Previous-capture register:
  - Updated with every capture.
  - Reset/`stat_clr` value is all-zero, so the first result counts ones.
- `total_toggles` adds `rsp_toggles` at the capture edge and saturates at 2^CNT_W-1 (no wrap).
- `stat_clr` coinciding with a capture: `total_toggles` = that capture's toggles, and the previous-capture register = that capture.
- `stat_clr` does not affect the FSM.

## Timing
- Reset values: FSM IDLE, `dut_in` 0, `rsp_valid` 0, `rsp_vec` 0, `rsp_id` 0, `rsp_toggles` 0, `total_toggles` 0, `busy` 0, `prio` 0, ready outputs 0 while `rst`.
- Request handshake in cycle T: `dut_in` is new in T+1, and `rsp_valid` rises in T+1+SETTLE_CYC.
- Minimum period per vector is SETTLE_CYC+2 cycles (with `rsp_ready` held high).
- Readies are combinational from valids and state; all other outputs are registered.
- `rst` mid-transaction: the transaction is abandoned with no response; state returns to the reset values above.

## Configuration
- `BVS_TOGGLE_CNT_EN` defined: previous-capture register, popcount logic and accumulator are present, as described above.
- `BVS_TOGGLE_CNT_EN` undefined:
  - `rsp_toggles` and `total_toggles` are tied to 0.
  - The previous-capture register and popcount logic are absent.
  - `stat_clr` is ignored.
  - FSM and timing are unchanged.

## Test plan
- Reset, then req0 vec = all-ones with SETTLE_CYC=2 and `dut_out` modelled by a netlist: `rsp_valid` rises 3 cycles after the handshake, `rsp_id`=0, `rsp_vec` matches the model, `rsp_toggles` = popcount(`rsp_vec`).
- Both valid continuously, `rsp_ready`=1: grants alternate 0,1,0,1, each vector takes 4 cycles, `busy` is high except in IDLE cycles.
- Hold `rsp_ready`=0 for 10 cycles in RESP: `rsp_*` stay stable, no ready is asserted, `dut_in` is unchanged; then release and verify return to IDLE.
- Apply the same vector twice: the second `rsp_toggles`=0 and `total_toggles` is unchanged.
- Preload `total_toggles` near saturation (CNT_W=8) and apply vectors yielding 66 toggles: the counter sticks at 255. Then assert `stat_clr` at a capture edge: total equals that capture's count.
- Assert `rst` during SETTLE: no `rsp_valid` appears, all outputs read reset values, and the next request completes normally with req0 priority.

Source files
------------

// File: rtl/bench_vec_sequencer.sv
// bench_vec_sequencer: round-robin sequencer sharing one combinational benchmark netlist between two requesters.
// Optional feature macro: BVS_TOGGLE_CNT_EN enables per-vector output-toggle counting and the saturating accumulator.
module bench_vec_sequencer #(
    parameter int IN_W       = 85,
    parameter int OUT_W      = 66,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 32,
    parameter int TW         = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_vec,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_vec,
    output logic             req1_ready,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [OUT_W-1:0] rsp_vec,
    output logic [TW-1:0]    rsp_toggles,
    output logic [CNT_W-1:0] total_toggles,
    input  logic             stat_clr,
    output logic             busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic [IN_W-1:0]  din_q, din_d;
    logic [OUT_W-1:0] vec_q, vec_d;
    logic             idle, accept, capture;

    assign idle       = state_q == IDLE;
    assign req0_ready = !rst && idle && req0_valid && (!req1_valid || !prio_q);
    assign req1_ready = !rst && idle && req1_valid && (!req0_valid || prio_q);
    assign accept     = req0_ready || req1_ready;
    assign capture    = state_q == SETTLE && cnt_q == 4'd0;

    assign dut_in    = din_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_id    = id_q;
    assign rsp_vec   = vec_q;
    assign busy      = !idle;

    // Next-state: accept loads the vector and settle count, capture samples the netlist, consumer handshake frees the slot.
    always_comb begin
        state_d = accept ? SETTLE : capture ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
        cnt_d   = accept ? 4'(SETTLE_CYC - 1) : (state_q == SETTLE && !capture) ? cnt_q - 4'd1 : cnt_q;
        din_d   = accept ? (req1_ready ? req1_vec : req0_vec) : din_q;
        id_d    = accept ? req1_ready : id_q;
        prio_d  = accept ? !req1_ready : prio_q;
        vec_d   = capture ? dut_out : vec_q;
    end

    // Sequencer registers; dut_in is only ever reloaded by an accept so the netlist sees no spurious switching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            din_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            din_q   <= din_d;
            vec_q   <= vec_d;
        end
    end

`ifdef BVS_TOGGLE_CNT_EN
    logic [OUT_W-1:0] prev_q, prev_d;
    logic [TW-1:0]    tog_q, tog_d, pop;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W:0]   sum;

    // Toggle count of the live netlist outputs against the previous capture, plus the saturating accumulator update.
    always_comb begin
        pop = '0;
        for (int i = 0; i < OUT_W; i++) pop = pop + TW'(dut_out[i] ^ prev_q[i]);
        sum    = {1'b0, tot_q} + (CNT_W + 1)'(pop);
        prev_d = capture ? dut_out : stat_clr ? '0 : prev_q;
        tog_d  = capture ? pop : tog_q;
        tot_d  = capture ? (stat_clr ? CNT_W'(pop) : sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0]) : stat_clr ? '0 : tot_q;
    end

    // Toggle statistics registers; a clear coinciding with a capture keeps that capture's contribution.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            tog_q  <= '0;
            tot_q  <= '0;
        end else begin
            prev_q <= prev_d;
            tog_q  <= tog_d;
            tot_q  <= tot_d;
        end
    end

    assign rsp_toggles   = tog_q;
    assign total_toggles = tot_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign rsp_toggles     = '0;
    assign total_toggles   = '0;
`endif
endmodule

// File: tb/tb_bench_vec_sequencer.sv
// tb_bench_vec_sequencer: randomized and directed checking of bench_vec_sequencer against a cycle-count transaction model.
module tb_bench_vec_sequencer;
    localparam int IN_W  = 85;
    localparam int OUT_W = 66;
    localparam int SC    = 2;
    localparam int CNT_W = 8;
    localparam int TW    = 7;
`ifdef BVS_TOGGLE_CNT_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [IN_W-1:0]  req0_vec, req1_vec, dut_in;
    logic [OUT_W-1:0] dut_out, rsp_vec;
    logic             rsp_valid, rsp_ready, rsp_id, stat_clr, busy;
    logic [TW-1:0]    rsp_toggles;
    logic [CNT_W-1:0] total_toggles;

    int n_tests = 0;
    int n_fail  = 0;

    bench_vec_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_vec(req0_vec), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_vec(req1_vec), .req1_ready(req1_ready),
        .dut_in(dut_in), .dut_out(dut_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_vec(rsp_vec),
        .rsp_toggles(rsp_toggles), .total_toggles(total_toggles),
        .stat_clr(stat_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] net(logic [IN_W-1:0] v);
        return v[OUT_W-1:0] + OUT_W'(v[IN_W-1:OUT_W]);
    endfunction

    assign dut_out = net(dut_in);

    function automatic int popc(logic [OUT_W-1:0] x);
        int c = 0;
        for (int i = 0; i < OUT_W; i++) c += int'(x[i]);
        return c;
    endfunction

    function automatic logic [IN_W-1:0] rnd();
        logic [95:0] r = {$urandom(), $urandom(), $urandom()};
        return r[IN_W-1:0];
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    bit               m_busy, m_id, m_prio, acc0, acc1;
    int               m_age, m_tog;
    longint           m_tot;
    logic [IN_W-1:0]  m_din;
    logic [OUT_W-1:0] m_rvec, m_prev;

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_prio = 0; m_age = 0; m_tog = 0; m_tot = 0;
        m_din = '0; m_rvec = '0; m_prev = '0;
    endtask

    task automatic cycle();
        bit e0, e1, resp;
        logic [OUT_W-1:0] cap;
        int t;
        #1;
        resp = m_busy && m_age > SC;
        e0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_prio);
        e1 = !rst && !m_busy && req1_valid && (!req0_valid || m_prio);
        check("req0_ready", 128'(req0_ready), 128'(e0));
        check("req1_ready", 128'(req1_ready), 128'(e1));
        check("busy", 128'(busy), 128'(m_busy));
        check("rsp_valid", 128'(rsp_valid), 128'(resp));
        check("dut_in", 128'(dut_in), 128'(m_din));
        check("rsp_id", 128'(rsp_id), 128'(m_id));
        check("rsp_vec", 128'(rsp_vec), 128'(m_rvec));
        check("rsp_toggles", 128'(rsp_toggles), 128'(m_tog));
        check("total_toggles", 128'(total_toggles), 128'(m_tot));
        acc0 = e0;
        acc1 = e1;
        if (rst) model_reset();
        else begin
            if (m_busy && m_age == SC) begin
                cap = net(m_din);
                t = TOG_EN ? popc(cap ^ m_prev) : 0;
                m_rvec = cap;
                if (TOG_EN) begin
                    m_tog  = t;
                    m_prev = cap;
                    m_tot  = stat_clr ? t : ((m_tot + t > 255) ? 255 : m_tot + t);
                end
            end else if (TOG_EN && stat_clr) begin
                m_prev = '0;
                m_tot  = 0;
            end
            if (resp && rsp_ready) m_busy = 0;
            else if (m_busy) m_age++;
            if (e0 || e1) begin
                m_busy = 1; m_age = 1; m_id = e1; m_prio = !e1;
                m_din = e1 ? req1_vec : req0_vec;
            end
        end
        @(negedge clk);
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic send(input bit id, input logic [IN_W-1:0] v, input bit clr);
        if (id) begin req1_valid = 1'b1; req1_vec = v; end
        else begin req0_valid = 1'b1; req0_vec = v; end
        for (int k = 0; k < SC + 2; k++) begin
            stat_clr = clr && m_busy && m_age == SC;
            cycle();
        end
        stat_clr = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0] v, v_hi, last;
        v_hi = '0;
        v_hi[OUT_W-1:0] = '1;
        rst = 1'b1; rsp_ready = 1'b1; stat_clr = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_vec = rnd(); req1_vec = rnd();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (8) cycle();
        send(0, '1, 0);
        v = rnd();
        send(0, v, 0);
        send(1, v, 0);
        repeat (16) begin
            if (!req0_valid) begin req0_valid = 1'b1; req0_vec = rnd(); end
            if (!req1_valid) begin req1_valid = 1'b1; req1_vec = rnd(); end
            cycle();
        end
        repeat (10) cycle();
        req0_valid = 1'b1; req0_vec = rnd(); rsp_ready = 1'b0;
        cycle();
        req1_valid = 1'b1; req1_vec = rnd();
        repeat (SC + 12) cycle();
        rsp_ready = 1'b1;
        repeat (6) cycle();
        for (int k = 0; k < 8; k++) send(0, k[0] ? v_hi : '0, 0);
        send(0, '0, 1);
        send(0, v_hi, 0);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        req0_valid = 1'b1; req0_vec = rnd();
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_vec = rnd(); req1_vec = rnd();
        repeat (10) cycle();
        last = rnd();
        repeat (1500) begin
            rst = ($urandom_range(0, 399) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            stat_clr = ($urandom_range(0, 19) == 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_vec = ($urandom_range(0, 3) == 0) ? last : rnd();
                last = req0_vec;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_vec = ($urandom_range(0, 3) == 0) ? last : rnd();
                last = req1_vec;
            end
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
